// File: rtl/mult_pkg.sv
// Shared types for the registered signed multiplier.
// Radix-4 Booth digit encoding lives here so the core and benches agree on it.
package mult_pkg;

  localparam int WIDTH  = 32;
  localparam int PWIDTH = 2 * WIDTH;

  typedef logic [WIDTH-1:0]  operand_t;
  typedef logic [PWIDTH-1:0] product_t;

  typedef enum logic [2:0] {
    BOOTH_Z,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_M1,
    BOOTH_M2
  } booth_e;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_e booth_dec(
    input logic [2:0] g
  );
    booth_e d;
    d = BOOTH_Z;
    unique case (g)
      3'b001,
      3'b010:  d = BOOTH_P1;
      3'b011:  d = BOOTH_P2;
      3'b100:  d = BOOTH_M2;
      3'b101,
      3'b110:  d = BOOTH_M1;
      default: d = BOOTH_Z;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/signed_mult_core.sv
// Combinational signed multiplier: radix-4 Booth partial products,
// a 3:2 carry-save tree, then one carry-propagate add.
module signed_mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW  = 2 * WIDTH;
  localparam int NPP = WIDTH / 2 + 1;
  localparam int NCS = NPP - 2;

  logic [WIDTH+2:0] be;
  logic [PW-1:0]    ae;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    pp [NPP];

  // Two sign copies on top give the extra (always-zero) digit.
  assign be = {{2{b[WIDTH-1]}}, b, 1'b0};
  assign ae = {{WIDTH{a[WIDTH-1]}}, a};

  always_comb begin
    mag = '0;
    for (int i = 0; i < NPP; i++) begin
      unique case (booth_dec(be[2*i +: 3]))
        BOOTH_P1: mag = ae;
        BOOTH_P2: mag = ae << 1;
        BOOTH_M1: mag = -ae;
        BOOTH_M2: mag = -(ae << 1);
        default:  mag = '0;
      endcase
      pp[i] = mag << (2 * i);
    end
  end

  // Rows are consumed in FIFO order: inputs 0..NPP-1 are the partial
  // products, CSA j emits rows NPP+2j (sum) and NPP+2j+1 (carry).
  for (genvar j = 0; j < NCS; j++) begin : csa
    logic [PW-1:0] in_v [3];
    logic [PW-1:0] s;
    logic [PW-1:0] c;

    for (genvar t = 0; t < 3; t++) begin : g_in
      localparam int K = 3 * j + t;
      if (K < NPP) begin : g_pp
        assign in_v[t] = pp[K];
      end else if (((K - NPP) % 2) == 0) begin : g_s
        assign in_v[t] = csa[(K - NPP) / 2].s;
      end else begin : g_c
        assign in_v[t] = csa[(K - NPP) / 2].c;
      end
    end

    assign s = in_v[0] ^ in_v[1] ^ in_v[2];
    assign c = ((in_v[0] & in_v[1]) |
                (in_v[0] & in_v[2]) |
                (in_v[1] & in_v[2])) << 1;
  end

  assign p = csa[NCS-1].s + csa[NCS-1].c;

endmodule

// File: rtl/verilog_multiplier_integrated.sv
// Registered signed multiplier: operand registers, Booth core, product register.
// Each register has its own synchronous active-low clear and load enable.
module verilog_multiplier_integrated
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 resetA,
  input  logic                 resetB,
  input  logic                 resetOut,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 enableA,
  input  logic                 enableB,
  input  logic                 enableOut,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   a_d, a_q;
  logic [WIDTH-1:0]   b_d, b_q;
  logic [2*WIDTH-1:0] product_d, product_q;
  logic [2*WIDTH-1:0] core_p;

  signed_mult_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (a_q),
    .b (b_q),
    .p (core_p)
  );

  always_comb begin
    a_d       = enableA   ? a      : a_q;
    b_d       = enableB   ? b      : b_q;
    product_d = enableOut ? core_p : product_q;
  end

  always_ff @(posedge clk) begin
    if (!resetA) a_q <= '0;
    else         a_q <= a_d;
    if (!resetB) b_q <= '0;
    else         b_q <= b_d;
    if (!resetOut) product_q <= '0;
    else           product_q <= product_d;
  end

  assign product = product_q;

endmodule

// File: tb/tb_verilog_multiplier_integrated.sv
// Scoreboard bench for the registered signed multiplier.
// Expected products are queued when enableOut is pulsed and checked after the edge.
module tb_verilog_multiplier_integrated;

  logic        clk = 1'b0;
  logic        resetA, resetB, resetOut;
  logic [31:0] a, b;
  logic        enableA, enableB, enableOut;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb [$];

  verilog_multiplier_integrated #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .resetA    (resetA),
    .resetB    (resetB),
    .resetOut  (resetOut),
    .a         (a),
    .b         (b),
    .enableA   (enableA),
    .enableB   (enableB),
    .enableOut (enableOut),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string tag);
    logic [63:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk(tag, product, e);
  endtask

  task automatic load(input logic [31:0] va, input logic [31:0] vb);
    a = va; b = vb;
    enableA = 1'b1; enableB = 1'b1;
    tick();
    enableA = 1'b0; enableB = 1'b0;
  endtask

  task automatic fire(input logic [63:0] exp, input string tag);
    enableOut = 1'b1;
    sb.push_back(exp);
    tick();
    enableOut = 1'b0;
    sb_pop(tag);
  endtask

  task automatic run_case(input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] exp, input string tag);
    load(va, vb);
    fire(exp, tag);
  endtask

  function automatic logic [63:0] model(input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  initial begin
    logic [31:0] ra, rb;
    a = '0; b = '0;
    enableA = 1'b1; enableB = 1'b1; enableOut = 1'b1;
    resetA = 1'b0; resetB = 1'b0; resetOut = 1'b0;
    sb.push_back(64'h0);
    tick();
    tick();
    sb_pop("reset");
    resetA = 1'b1; resetB = 1'b1; resetOut = 1'b1;
    enableA = 1'b0; enableB = 1'b0; enableOut = 1'b0;
    fire(64'h0, "reset_operands");

    run_case(32'h00087234, 32'h00000348, 64'h000000001BB6BAA0, "pos_small");
    run_case(32'h50647236, 32'h50612336, 64'h193DE4CED7437964, "pos_big");
    run_case(32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564, "mix_small");
    run_case(32'hFFFFFEFD, 32'h00087234, 64'hFFFFFFFFF7747564, "mix_small_sw");
    run_case(32'h50647236, 32'hB887CAAF, 64'hE98E647F4142AEEA, "mix_big");
    run_case(32'hB887CAAF, 32'h50647236, 64'hE98E647F4142AEEA, "mix_big_sw");
    run_case(32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609, "neg_small");
    run_case(32'hB887CAAF, 32'h887CAAF3, 64'h215D8B0A7A419A1D, "neg_big");
    run_case(32'h80000000, 32'h80000000, 64'h4000000000000000, "min_sq");
    run_case(32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, "min_max");
    run_case(32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, "max_min");
    run_case(32'h00000001, 32'h50647236, 64'h0000000050647236, "one_a");
    run_case(32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF, "one_b");
    run_case(32'h00000000, 32'hB887CAAF, 64'h0, "zero_a");
    run_case(32'h50647236, 32'h00000000, 64'h0, "zero_b");
    run_case(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, "m1_sq");

    // Hold: operands change without enableOut.
    run_case(32'h00000003, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, "pre_hold");
    load(32'h12345678, 32'h00000010);
    tick();
    chk("hold", product, 64'hFFFFFFFFFFFFFFF1);
    fire(64'h0000000123456780, "after_hold");

    // Same-edge load and capture takes the old operands.
    a = 32'h00000007; b = 32'h00000009;
    enableA = 1'b1; enableB = 1'b1;
    fire(64'h0000000123456780, "same_edge_old");
    enableA = 1'b0; enableB = 1'b0;
    fire(64'h000000000000003F, "same_edge_new");

    // Operand clear: product holds, next capture loads 0.
    resetA = 1'b0;
    tick();
    resetA = 1'b1;
    chk("rstA_hold", product, 64'h000000000000003F);
    fire(64'h0, "rstA_zero");
    load(32'h00000005, 32'h00000006);
    resetB = 1'b0;
    tick();
    resetB = 1'b1;
    fire(64'h0, "rstB_zero");

    // resetOut beats enableOut.
    load(32'h00000005, 32'h00000006);
    fire(64'h000000000000001E, "pre_rstOut");
    resetOut = 1'b0;
    fire(64'h0, "rstOut_wins");
    resetOut = 1'b1;
    fire(64'h000000000000001E, "post_rstOut");

    for (int i = 0; i < 12; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 4 == 1) ra[31] = 1'b1;
      if (i % 4 == 2) rb[31] = 1'b1;
      run_case(ra, rb, model(ra, rb), $sformatf("rand%0d", i));
    end

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
